// File: rtl/apb_queued_requester.sv
// APB requester with a small command queue, address decode to one-hot PSEL,
// wait-state timeout and in-order single-cycle completion pulses.
module apb_queued_requester #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_COMP     = 5,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          REGION_SHIFT = 12,
  parameter int          TIMEOUT      = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [NUM_COMP-1:0]   PSEL,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } state_t;

  state_t state_q, state_d;

  logic                  wr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] ad_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wd_mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  logic                  full, empty, push, pop;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr, head_off, head_ridx;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_ok;
  logic [NUM_COMP-1:0]   head_sel;

  logic                  hold_write_q;
  logic [NUM_COMP-1:0]   psel_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [TW-1:0]         wcnt_q;
  logic                  tmo;

  logic                  done, done_err;
  logic [DATA_WIDTH-1:0] done_rdata;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  active;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_ff @(posedge PCLK) begin
    if (push) begin
      wr_mem[wptr_q] <= cmd_write;
      ad_mem[wptr_q] <= cmd_addr;
      wd_mem[wptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  assign head_write = wr_mem[rptr_q];
  assign head_addr  = ad_mem[rptr_q];
  assign head_wdata = wd_mem[rptr_q];
  assign head_off   = head_addr - BASE;
  assign head_ridx  = head_off >> REGION_SHIFT;
  assign head_ok    = (head_addr >= BASE) &&
                      (head_ridx < ADDR_WIDTH'(NUM_COMP));

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_COMP; i++)
      head_sel[i] = (head_ridx == ADDR_WIDTH'(i));
  end

  assign tmo = (state_q == ACCESS) && !PREADY &&
               (wcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    unique case (state_q)
      IDLE:   pop = !empty;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done     = 1'b1;
          done_err = PSLVERR;
          if (!hold_write_q && !PSLVERR)
            done_rdata = PRDATA;
        end else if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      DERR: begin
        done     = 1'b1;
        done_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // completion pops the next head in the same cycle: no idle gap
    if (done) begin
      state_d = IDLE;
      pop     = !empty;
    end
    if (pop) state_d = head_ok ? SETUP : DERR;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      hold_write_q <= 1'b0;
      psel_q       <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        hold_write_q <= head_write;
        wcnt_q       <= '0;
        if (head_ok) begin
          psel_q   <= head_sel;
          paddr_q  <= head_addr;
          pwdata_q <= head_wdata;
        end
      end else if (state_q == ACCESS && !PREADY) begin
        wcnt_q <= wcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done;
      rsp_err_q   <= done && done_err;
      rsp_rdata_q <= done ? done_rdata : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign active  = (state_q == SETUP) || (state_q == ACCESS);
  assign PSEL    = active ? psel_q : '0;
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = active && hold_write_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_queued_requester.sv
// Bench for apb_queued_requester: directed and random commands against
// a queue-based reference model with a reactive APB completer.
module tb_apb_queued_requester;

  localparam int          NC   = 5;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [NC-1:0] PSEL;
  logic        PENABLE;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_queued_requester dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    logic        slv;
    logic [31:0] rd;
  } xfer_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    logic        apb;
  } rsp_t;

  xfer_t apb_q[$];
  rsp_t  exp_q[$];
  int    done_q[$];
  int    setup_cyc[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  always @(posedge PCLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dec_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 12) < 32'(NC));
  endfunction

  function automatic logic [63:0] sel_of(input logic [31:0] a);
    return 64'(1) << ((a - BASE) >> 12);
  endfunction

  task automatic push(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int waits,
                      input logic slv, input logic [31:0] rd);
    xfer_t x;
    rsp_t  r;
    int    n;
    n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 300) begin
      chk("push_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge PCLK);
      x = '{w, a, d, waits, slv, rd};
      r.apb = dec_ok(a);
      r.err = 1'b1;
      r.rd  = '0;
      if (r.apb) begin
        apb_q.push_back(x);
        if (waits < TO && !slv) begin
          r.err = 1'b0;
          r.rd  = w ? 32'h0 : rd;
        end
      end
      exp_q.push_back(r);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge PCLK);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 0);
    repeat (2) @(negedge PCLK);
  endtask

  xfer_t cur;
  int    acc = 0;
  bit    busy = 1'b0;

  // reactive completer: checks the request and plans PREADY per cycle
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      busy   = 1'b0;
      PREADY = 1'b0;
    end else if (PSEL != '0 && !PENABLE) begin
      setup_cyc.push_back(cyc);
      PREADY = 1'b0;
      if (apb_q.size() == 0) begin
        chk("unexpected_setup", 64'(PSEL), 0);
      end else begin
        cur  = apb_q.pop_front();
        busy = 1'b1;
        acc  = 0;
        chk("setup_psel", 64'(PSEL), sel_of(cur.a));
        chk("setup_paddr", PADDR, cur.a);
        chk("setup_pwrite", PWRITE, cur.w);
        if (cur.w) chk("setup_pwdata", PWDATA, cur.d);
      end
    end else if (PENABLE) begin
      acc++;
      if (!busy) begin
        chk("access_overstay", PENABLE, 0);
        PREADY = 1'b0;
      end else begin
        chk("access_psel", 64'(PSEL), sel_of(cur.a));
        chk("access_paddr", PADDR, cur.a);
        chk("access_pwrite", PWRITE, cur.w);
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
        PREADY  = 1'b0;
        if (acc > cur.waits || acc == TO) begin
          chk("access_cycles", 64'(acc),
              64'((cur.waits + 1 < TO) ? cur.waits + 1 : TO));
          done_q.push_back(cyc);
          busy = 1'b0;
          if (acc > cur.waits) begin
            PREADY  = 1'b1;
            PRDATA  = cur.rd;
            PSLVERR = cur.slv;
          end
        end
      end
    end else begin
      PREADY = 1'b0;
      PRDATA = $urandom;
      chk("idle_pwrite", PWRITE, 0);
    end
  end

  rsp_t rr;
  int   dc;

  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        rr = exp_q.pop_front();
        chk("rsp_err", rsp_err, rr.err);
        chk("rsp_rdata", rsp_rdata, rr.rd);
        if (rr.apb) begin
          if (done_q.size() == 0) begin
            chk("rsp_before_done", rsp_valid, 0);
          end else begin
            dc = done_q.pop_front();
            chk("rsp_latency", 64'(cyc), 64'(dc + 1));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r, w8, n;

    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_apb", {PSEL, PENABLE, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    push(1'b1, 32'h1000_1004, 32'hA5A5_A5A5, 0, 1'b0, 32'h0);
    drain("single_write", 100);

    setup_cyc.delete();
    push(1'b0, 32'h1000_0100, 32'h0, 10, 1'b0, 32'h1111_2222);
    for (int i = 0; i < 4; i++)
      push(1'b0, BASE + 32'(i) * 32'h1000, 32'h0, 0, 1'b0,
           32'hC0DE_0000 + 32'(i));
    #1 chk("full_cmd_ready", cmd_ready, 0);
    drain("burst_drain", 200);
    chk("burst_setups", 64'(setup_cyc.size()), 5);
    if (setup_cyc.size() == 5)
      for (int k = 1; k < 4; k++)
        chk("burst_gap", 64'(setup_cyc[k+1] - setup_cyc[k]), 2);
    chk("ready_after_burst", cmd_ready, 1);

    push(1'b0, 32'h1000_3010, 32'h0, 2, 1'b0, 32'h1234_5678);
    drain("wait_read", 100);

    push(1'b1, 32'h2000_0000, 32'h5555_0000, 0, 1'b0, 32'h0);
    push(1'b1, 32'h1000_4008, 32'h5555_0001, 1, 1'b0, 32'h0);
    push(1'b0, 32'h0FFF_FFFC, 32'h0, 0, 1'b0, 32'h0);
    push(1'b0, 32'h1000_5000, 32'h0, 0, 1'b0, 32'h0);
    push(1'b0, 32'h1000_4FFC, 32'h0, 0, 1'b0, 32'h4444_4444);
    drain("decode_edges", 200);

    push(1'b0, 32'h1000_2000, 32'h0, 40, 1'b0, 32'h9999_9999);
    push(1'b0, 32'h1000_0008, 32'h0, 1, 1'b1, 32'hDEAD_BEEF);
    push(1'b1, 32'h1000_1000, 32'h7777_7777, 15, 1'b1, 32'h0);
    push(1'b0, 32'h1000_1000, 32'h0, 15, 1'b0, 32'hABCD_0015);
    drain("timeout_slverr", 300);

    for (int i = 0; i < 40; i++) begin
      a  = 32'h0FFF_E000 + (32'($urandom_range(0, 9 * 4096 - 1)) & ~32'h3);
      r  = $urandom_range(0, 9);
      w8 = (r == 9) ? 17 : r % 4;
      push(1'($urandom_range(0, 1)), a, $urandom, w8,
           ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 6)) @(negedge PCLK);
    end
    drain("random_drain", 3000);

    push(1'b0, 32'h1000_2004, 32'h0, 50, 1'b0, 32'h0);
    push(1'b1, 32'h1000_3000, 32'hFEED_0001, 0, 1'b0, 32'h0);
    push(1'b0, 32'h1000_4000, 32'h0, 0, 1'b0, 32'h0);
    n = 0;
    while (!PENABLE && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("reset_reached_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_apb", {PSEL, PENABLE, PWRITE}, 0);
    chk("arst_paddr", PADDR, 0);
    chk("arst_pwdata", PWDATA, 0);
    chk("arst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    apb_q.delete();
    exp_q.delete();
    done_q.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (30) @(negedge PCLK);

    push(1'b0, 32'h1000_0040, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
    drain("post_reset", 100);
    chk("end_apb_q", 64'(apb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
